fill_shift_right_pipe: RTL

- Pipelined logarithmic right shifter. It is the right-shift counterpart to the left-shift fill-literal path.
- Produces `data >> amt`, or `'1 >> amt` when in mask mode, with a selectable fill: zero ('0), one ('1) or sign.
- Carries the fill semantics of unbased unsized literals into a clocked, back-pressured datapath.
- Used as a mask/alignment generator feeding downstream units over a valid/ready interface.

---
 rtl/fill_shift_pkg.sv | 21 ++
 rtl/fill_shift_stage.sv | 52 +++++
 rtl/fill_shift_right_pipe.sv | 95 +++++++++
 3 files changed

// File: rtl/fill_shift_pkg.sv
// rtl/fill_shift_pkg.sv - shared types for the fill-literal right-shift pipeline
package fill_shift_pkg;

    localparam int FS_WIDTH = 64;
    localparam int FS_AMT_W = 8;

    typedef enum logic [1:0] {
        FILL_ZERO = 2'b00,
        FILL_ONE  = 2'b01,
        FILL_SIGN = 2'b10,
        FILL_RSVD = 2'b11
    } fill_mode_e;

    typedef struct packed {
        logic [FS_WIDTH-1:0] data;
        logic [FS_AMT_W-1:0] amt;
        logic                fill_bit;
        logic                ovf;
    } fs_payload_t;

endpackage

// File: rtl/fill_shift_stage.sv
// rtl/fill_shift_stage.sv - one register slice: conditional 2**STAGE right shift with fill
module fill_shift_stage #(
    parameter int WIDTH = 64,
    parameter int AMT_W = 8,
    parameter int STAGE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_fill,
    input  logic             in_ovf,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [AMT_W-1:0] out_amt,
    output logic             out_fill,
    output logic             out_ovf
);

    localparam int SH = 1 << STAGE;

    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = in_data;
        if (in_amt[STAGE]) begin
            shifted = {{SH{in_fill}}, in_data[WIDTH-1:SH]};
        end
    end

    // ready means this slice is empty or its contents move on this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_amt   <= '0;
            out_fill  <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= shifted;
                out_amt  <= in_amt;
                out_fill <= in_fill;
                out_ovf  <= in_ovf;
            end
        end
    end

endmodule

// File: rtl/fill_shift_right_pipe.sv
// rtl/fill_shift_right_pipe.sv - pipelined log right shifter with zero/one/sign fill
module fill_shift_right_pipe
    import fill_shift_pkg::*;
#(
    parameter int WIDTH = FS_WIDTH,
    parameter int AMT_W = FS_AMT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_fill,
    input  logic             in_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [AMT_W-1:0] WIDTH_AMT = AMT_W'(WIDTH);

    fill_mode_e       mode;
    logic [WIDTH-1:0] operand;
    logic             fill_bit;
    logic             ovf;

    logic [SHW:0]     v_c;
    logic [SHW:0]     rdy;
    logic [SHW:0]     f_c;
    logic [SHW:0]     o_c;
    logic [WIDTH-1:0] d_c [SHW+1];
    logic [AMT_W-1:0] a_c [SHW+1];

    // Overflow is folded in up front: an all-fill word stays all-fill through every stage
    always_comb begin
        operand = in_src ? {WIDTH{1'b1}} : in_data;
        mode    = fill_mode_e'(in_fill);
        case (mode)
            FILL_ONE:  fill_bit = 1'b1;
            FILL_SIGN: fill_bit = operand[WIDTH-1];
            default:   fill_bit = 1'b0;
        endcase
        ovf = (in_amt >= WIDTH_AMT);
    end

    assign v_c[0] = in_valid;
    assign d_c[0] = ovf ? {WIDTH{fill_bit}} : operand;
    assign a_c[0] = in_amt;
    assign f_c[0] = fill_bit;
    assign o_c[0] = ovf;

    // Ready ripples back from the output; a bubble anywhere lets everything above it advance
    always_comb begin
        rdy      = '0;
        rdy[SHW] = out_ready;
        for (int k = SHW - 1; k >= 0; k--) begin
            rdy[k] = !v_c[k+1] || rdy[k+1];
        end
    end

    assign in_ready = rdy[0];

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        fill_shift_stage #(
            .WIDTH (WIDTH),
            .AMT_W (AMT_W),
            .STAGE (k)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (v_c[k]),
            .ready     (rdy[k]),
            .in_data   (d_c[k]),
            .in_amt    (a_c[k]),
            .in_fill   (f_c[k]),
            .in_ovf    (o_c[k]),
            .out_valid (v_c[k+1]),
            .out_data  (d_c[k+1]),
            .out_amt   (a_c[k+1]),
            .out_fill  (f_c[k+1]),
            .out_ovf   (o_c[k+1])
        );
    end

    assign out_valid = v_c[SHW];
    assign out_data  = d_c[SHW];
    assign out_ovf   = o_c[SHW];

    logic unused_tail;
    assign unused_tail = ^{a_c[SHW], f_c[SHW]};

endmodule
